floating_divider: RTL and testbench
===================================

// Module: floating_divider
// PURPOSE
//  Sequential IEEE-754 single-precision divider: quotient = dividendA / divisorB.
//  Companion inverse of the floating-point multiplier in the calculator datapath.
//  Unpacks operands, divides 24-bit mantissas by restoring division (1 bit/cycle),
//  then renormalises and packs. Single outstanding operation, start/done handshake.
// PARAMETERS
//  MANT_W   24            significand width incl. hidden 1; only 24 supported
//  QNAN     32'h7FC00000  canonical NaN returned for all invalid cases
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   request; sampled only in IDLE
//  dividendA    in   32  IEEE-754 single dividend; captured on accepted start
//  divisorB     in   32  IEEE-754 single divisor; captured on accepted start
//  quotient     out  32  result; valid when done=1, held until next done
//  busy         out  1   high from cycle after accepted start until done cycle inclusive
//  done         out  1   one-cycle pulse, result valid
//  div_by_zero  out  1   finite nonzero / zero; valid with done, held
//  invalid      out  1   NaN input, 0/0 or Inf/Inf; valid with done, held
//  overflow     out  1   exponent > 254; valid with done, held
//  underflow    out  1   exponent < 1; valid with done, held
// BEHAVIOUR
//  Reset: state=IDLE; quotient=0, busy=0, done=0, all flags=0. Async assert clears
//   an in-flight op immediately; no done is produced for it.
//  FSM: IDLE -> SETUP -> DIVIDE(x24) -> PACK -> IDLE; SETUP -> PACK on special case.
//   Edge 0: start=1 in IDLE; operands latched. Edge 1: SETUP. Edges 2..25: DIVIDE.
//   Edge 26: PACK registers quotient/flags, done=1 for the following cycle.
//   Special cases: PACK at edge 2, done high after edge 2.
//  start while busy ignored; operand changes after edge 0 have no effect.
//  Back-to-back: start may be asserted in the done cycle (state is IDLE then).
//  Unpack: s=A[31]^B[31]; exp field 0 => operand treated as zero (denormals flushed);
//   mantissa mX={1,X[22:0]}.
//  Specials (SETUP, priority order):
//   NaN in either -> QNAN, invalid. 0/0 or Inf/Inf -> QNAN, invalid.
//   x/0 (x finite nonzero) -> {s,8'hFF,23'b0}, div_by_zero. Inf/finite -> signed Inf.
//   finite/Inf -> {s,31'b0}. 0/finite nonzero -> {s,31'b0}. No flags except listed.
//  Exponent: 10-bit signed e = eA - eB + 127. If mA < mB: mA<<=1, e-=1 (in SETUP).
//  DIVIDE: 25-bit remainder R=mA initially; per cycle: if R>=mB {q=(q<<1)|1; R-=mB}
//   else q<<=1; then R<<=1. After 24 iters q[23]=1 guaranteed.
//  Rounding: truncation (toward zero); fraction = q[22:0]; remainder discarded.
//  PACK: e>254 -> {s,8'hFF,23'b0}, overflow. e<1 -> {s,31'b0}, underflow.
//   else {s,e[7:0],q[22:0]}.
//  Flags and quotient update only in PACK; all cleared-to-new each PACK.
// TESTING
//  6.0/2.0: 40C00000/40000000 -> 40400000, done exactly 26 cycles after start edge.
//  1.0/3.0: 3F800000/40400000 -> 3EAAAAAA (truncated), no flags; -6/2 -> C0400000.
//  C0000000/00000000 -> FF800000, div_by_zero=1, done 2 cycles after start;
//   00000000/00000000 -> 7FC00000, invalid=1.
//  7F000000/3E800000 -> 7F800000 overflow=1; 00800000/40000000 -> 00000000 underflow=1.
//  Assert start again at cycle 10 with other operands -> ignored, first result returned.
//  Pulse rst at cycle 12 of an op -> busy=0, done never pulses, quotient=0; next op correct.

Source files
------------

// File: rtl/floating_divider.sv
// Sequential IEEE-754 single-precision divider (quotient = dividendA / divisorB).
// Restoring mantissa division at one quotient bit per cycle, truncating rounding.
module floating_divider #(
    parameter int          MANT_W = 24,
    parameter logic [31:0] QNAN   = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividendA,
    input  logic [31:0] divisorB,
    output logic [31:0] quotient,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {IDLE, SETUP, DIVIDE, PACK} state_t;

    state_t state, state_next;

    logic [31:0]       a_r, b_r;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [24:0]       rem_r;
    logic [23:0]       mb_r;
    logic [22:0]       q_r;
    logic [4:0]        cnt_r;
    logic              special_r;
    logic [31:0]       spec_q_r;
    logic              spec_dz_r, spec_inv_r;

    logic [7:0]        ea, eb;
    logic              sgn;
    logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [23:0]       ma, mb;
    logic signed [9:0] e_base;
    logic              spec_hit, spec_dz, spec_inv;
    logic [31:0]       spec_q;
    logic [24:0]       rem_diff;

    assign ea     = a_r[30:23];
    assign eb     = b_r[30:23];
    assign sgn    = a_r[31] ^ b_r[31];
    assign zero_a = (ea == 8'h00);
    assign zero_b = (eb == 8'h00);
    assign inf_a  = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
    assign nan_a  = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
    assign ma     = {1'b1, a_r[22:0]};
    assign mb     = {1'b1, b_r[22:0]};
    assign e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    assign rem_diff = rem_r - {1'b0, mb_r};

    // Special operands resolved in priority order; first match wins.
    always_comb begin
        spec_hit = 1'b1;
        spec_dz  = 1'b0;
        spec_inv = 1'b0;
        spec_q   = '0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_q   = QNAN;
            spec_inv = 1'b1;
        end else if (zero_b && !inf_a) begin
            spec_q  = {sgn, 8'hFF, 23'd0};
            spec_dz = 1'b1;
        end else if (inf_a) begin
            spec_q = {sgn, 8'hFF, 23'd0};
        end else if (inf_b || zero_a) begin
            spec_q = {sgn, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = spec_hit ? PACK : DIVIDE;
            DIVIDE:  if (cnt_r == 5'(MANT_W - 1)) state_next = PACK;
            PACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            rem_r       <= '0;
            mb_r        <= '0;
            q_r         <= '0;
            cnt_r       <= '0;
            special_r   <= 1'b0;
            spec_q_r    <= '0;
            spec_dz_r   <= 1'b0;
            spec_inv_r  <= 1'b0;
            quotient    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            // Busy covers the done cycle too, and stays up if a new op starts then.
            busy <= (state_next != IDLE) || (state == PACK);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= dividendA;
                        b_r <= divisorB;
                    end
                end
                SETUP: begin
                    sign_r     <= sgn;
                    special_r  <= spec_hit;
                    spec_q_r   <= spec_q;
                    spec_dz_r  <= spec_dz;
                    spec_inv_r <= spec_inv;
                    mb_r       <= mb;
                    cnt_r      <= '0;
                    q_r        <= '0;
                    if (ma < mb) begin
                        rem_r <= {ma, 1'b0};
                        exp_r <= e_base - 10'sd1;
                    end else begin
                        rem_r <= {1'b0, ma};
                        exp_r <= e_base;
                    end
                end
                DIVIDE: begin
                    // The guaranteed leading 1 shifts out of the 23-bit q_r on the last step.
                    if (rem_r >= {1'b0, mb_r}) begin
                        q_r   <= {q_r[21:0], 1'b1};
                        rem_r <= {rem_diff[23:0], 1'b0};
                    end else begin
                        q_r   <= {q_r[21:0], 1'b0};
                        rem_r <= {rem_r[23:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 5'd1;
                end
                PACK: begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b0;
                    invalid     <= 1'b0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    if (special_r) begin
                        quotient    <= spec_q_r;
                        div_by_zero <= spec_dz_r;
                        invalid     <= spec_inv_r;
                    end else if (exp_r > 10'sd254) begin
                        quotient <= {sign_r, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else if (exp_r < 10'sd1) begin
                        quotient  <= {sign_r, 31'd0};
                        underflow <= 1'b1;
                    end else begin
                        quotient <= {sign_r, exp_r[7:0], q_r};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_divider.sv
// Directed-vector bench for floating_divider: results, flags, latency,
// ignored restarts, async reset mid-operation and back-to-back operation.
module tb_floating_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividendA = '0;
    logic [31:0] divisorB = '0;
    logic [31:0] quotient;
    logic        busy, done, div_by_zero, invalid, overflow, underflow;

    int tests = 0;
    int fails = 0;

    floating_divider #(.MANT_W(24), .QNAN(32'h7FC00000)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividendA(dividendA), .divisorB(divisorB),
        .quotient(quotient), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .invalid(invalid),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Present operands with start for exactly one rising edge (edge 0).
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dividendA = a;
        divisorB  = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after edge 0 until done is seen; bounded at 100.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (quotient !== 32'h0) begin fails++; $display("FAIL reset_quotient got %h want 00000000", quotient); end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        tests++;
        if ({div_by_zero, invalid, overflow, underflow} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {div_by_zero, invalid, overflow, underflow});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Vectors: dividend, divisor, quotient, {dz,inv,ov,un}, latency.
    task automatic run_vectors(input string name, input logic [31:0] va[], input logic [31:0] vb[],
                               input logic [31:0] vq[], input logic [3:0] vf[], input int vlat);
        int lat;
        for (int i = 0; i < va.size(); i++) begin
            @(negedge clk);
            issue(va[i], vb[i]);
            wait_done(lat);
            tests++;
            if (lat != vlat) begin fails++; $display("FAIL %s_latency[%0d] got %0d want %0d", name, i, lat, vlat); end
            tests++;
            if (quotient !== vq[i]) begin fails++; $display("FAIL %s_quotient[%0d] got %h want %h", name, i, quotient, vq[i]); end
            tests++;
            if ({div_by_zero, invalid, overflow, underflow} !== vf[i]) begin
                fails++; $display("FAIL %s_flags[%0d] got %b want %b", name, i, {div_by_zero, invalid, overflow, underflow}, vf[i]);
            end
        end
    endtask

    task automatic test_normal();
        logic [31:0] va[] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h7F000000, 32'h00800000};
        logic [31:0] vb[] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h3E800000, 32'h40000000};
        logic [31:0] vq[] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000, 32'h00000000};
        logic [3:0]  vf[] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
        run_vectors("normal", va, vb, vq, vf, 26);
    endtask

    task automatic test_specials();
        logic [31:0] va[] = '{32'hC0000000, 32'h00000000, 32'h7FC00000, 32'h7F800000,
                              32'hFF800000, 32'h3F800000, 32'h80000000, 32'h00400000};
        logic [31:0] vb[] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h7F800000,
                              32'h40000000, 32'h7F800000, 32'h40000000, 32'h3F800000};
        logic [31:0] vq[] = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                              32'hFF800000, 32'h00000000, 32'h80000000, 32'h00000000};
        logic [3:0]  vf[] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000};
        run_vectors("special", va, vb, vq, vf, 2);
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000);
        dividendA = 32'h12345678;
        divisorB  = 32'h3F800000;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) begin
                start = 1'b1; dividendA = 32'h3F800000; divisorB = 32'h40400000;
            end else if (lat == 11) begin
                start = 1'b0;
            end
        end
        tests++;
        if (lat != 26) begin fails++; $display("FAIL ignore_latency got %0d want 26", lat); end
        tests++;
        if (quotient !== 32'h40400000) begin fails++; $display("FAIL ignore_quotient got %h want 40400000", quotient); end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL ignore_idle_after got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_reset_midop();
        int lat;
        int seen = 0;
        @(negedge clk);
        issue(32'hC0C00000, 32'h40000000);
        repeat (11) @(posedge clk);
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || quotient !== 32'h0) begin
            fails++; $display("FAIL rst_midop_clear got busy=%b q=%h want 0 00000000", busy, quotient);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL rst_midop_no_done got %0d pulses want 0", seen); end
        @(negedge clk);
        issue(32'h3F800000, 32'h40400000);
        wait_done(lat);
        tests++;
        if (lat != 26 || quotient !== 32'h3EAAAAAA) begin
            fails++; $display("FAIL rst_midop_next got lat=%0d q=%h want 26 3EAAAAAA", lat, quotient);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_after_start got %b want 1", busy); end
        wait_done(lat);
        tests++;
        if (busy !== 1'b1 || quotient !== 32'h40400000) begin
            fails++; $display("FAIL b2b_first got busy=%b q=%h want 1 40400000", busy, quotient);
        end
        issue(32'hC0000000, 32'h00000000);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, done); end
        wait_done(lat);
        tests++;
        if (lat != 2 || quotient !== 32'hFF800000 || div_by_zero !== 1'b1) begin
            fails++; $display("FAIL b2b_second got lat=%0d q=%h dz=%b want 2 FF800000 1", lat, quotient, div_by_zero);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
